// File: rtl/ibuff_fill_stage_pkg.sv
// ibuff_fill_stage_pkg: shared types and sizes for the decode-to-instruction-buffer fill stage
package ibuff_fill_stage_pkg;
    localparam int FETCH_W      = 4;
    localparam int SLOTS        = 2 * FETCH_W;
    localparam int REN_PKT_SIZE = 16;
    localparam int CNT_W        = $clog2(SLOTS) + 1;
    typedef struct packed {
        logic                    valid;
        logic [REN_PKT_SIZE-2:0] payload;
    } renPkt;
    typedef struct packed {
        renPkt [SLOTS-1:0] pkts;
        logic  [CNT_W-1:0] count;
    } bundle_t;
endpackage

// File: rtl/ibuff_fill_stage_pkt_compactor.sv
// pkt_compactor: moves valid packets to the lowest slots in program order and counts them
//   inPkt    sparse bundle, slot 0 is oldest
//   outPkt   compacted bundle, slots at or above popCount are all-zero (invalid)
//   popCount number of valid packets
module pkt_compactor
    import ibuff_fill_stage_pkg::*;
(
    input  renPkt [SLOTS-1:0] inPkt,
    output renPkt [SLOTS-1:0] outPkt,
    output logic  [CNT_W-1:0] popCount
);
    always_comb begin
        outPkt   = '0;
        popCount = '0;
        for (int i = 0; i < SLOTS; i++)
            if (inPkt[i].valid) begin
                outPkt[popCount[CNT_W-2:0]] = inPkt[i];
                popCount = popCount + CNT_W'(1);
            end
    end
endmodule

// File: rtl/ibuff_fill_stage.sv
// ibuff_fill_stage: two-bundle skid queue between Decode and the instruction buffer
//   clk, reset (async, active-low)  clock and reset
//   flush_i                         mispredict flush, empties the queue on the next edge
//   decPacket_i, decValid_i         sparse bundle offered by Decode
//   decReady_o                      a bundle can be accepted (registered state only)
//   stallFetch_i                    blocks presentation to the instruction buffer
//   instBufferFull_i                instruction buffer cannot take a bundle this cycle
//   ibPacket_o, decodeReady_o       compacted head bundle and its offer
//   pktCount_o, bundleCount_o       valid packets in head bundle, bundles held
module ibuff_fill_stage
    import ibuff_fill_stage_pkg::*;
#(
    parameter int FETCH_WIDTH = FETCH_W,
    parameter int PKT_W       = REN_PKT_SIZE
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush_i,
    input  logic [PKT_W-1:0]                decPacket_i [0:2*FETCH_WIDTH-1],
    input  logic                            decValid_i,
    output logic                            decReady_o,
    input  logic                            stallFetch_i,
    input  logic                            instBufferFull_i,
    output logic [PKT_W-1:0]                ibPacket_o [0:2*FETCH_WIDTH-1],
    output logic                            decodeReady_o,
    output logic [$clog2(2*FETCH_WIDTH):0]  pktCount_o,
    output logic [1:0]                      bundleCount_o
);
    renPkt [SLOTS-1:0] inPkt;
    renPkt [SLOTS-1:0] compPkt;
    logic  [CNT_W-1:0] popCount;
    bundle_t           bundles [2];
    logic              headPtr;
    logic              tailPtr;
    logic [1:0]        count;
    logic              enq;
    logic              store;
    logic              deq;

    pkt_compactor compactor (.inPkt(inPkt), .outPkt(compPkt), .popCount(popCount));

    assign decReady_o    = count != 2'd2;
    assign enq           = decValid_i & decReady_o & ~flush_i;
    // Empty bundles complete the handshake but occupy no entry.
    assign store         = enq & (popCount != '0);
    assign decodeReady_o = (count != 2'd0) & ~stallFetch_i;
    assign deq           = decodeReady_o & ~instBufferFull_i & ~flush_i;
    assign bundleCount_o = count;
    assign pktCount_o    = count != 2'd0 ? bundles[headPtr].count : '0;

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        assign inPkt[i]      = decPacket_i[i];
        assign ibPacket_o[i] = count != 2'd0 ? bundles[headPtr].pkts[i] : '0;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            count   <= 2'd0;
            headPtr <= 1'b0;
            tailPtr <= 1'b0;
        end else if (flush_i) begin
            count   <= 2'd0;
            headPtr <= 1'b0;
            tailPtr <= 1'b0;
        end else begin
            if (store) tailPtr <= ~tailPtr;
            if (deq) headPtr <= ~headPtr;
            count <= count + {1'b0, store} - {1'b0, deq};
        end

    // Entry payload needs no reset: outputs are masked whenever count is 0.
    always_ff @(posedge clk)
        if (store) bundles[tailPtr] <= '{pkts: compPkt, count: popCount};
endmodule

// File: doc/ibuff_fill_stage.md
# ibuff_fill_stage

Two-bundle skid stage between Decode and the instruction buffer. It accepts one decoded bundle per cycle of up to 2*FETCH_WIDTH rename packets with sparse valid bits. Each bundle is compacted so valid packets occupy the lowest slots in program order. Bundles are held until the instruction buffer can take them, and are presented on the instruction buffer's write interface (`ibPacket`, `decodeReady`, `instBufferFull`, `stallFetch`). Back-pressure is absorbed here, so Decode never has to re-present a bundle.

## Interface
- FETCH_WIDTH, default 4: fetch lanes; SLOTS = 2*FETCH_WIDTH packet slots per bundle.
- PKT_W, default `REN_PKT_SIZE`: width of one renPkt.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately when low.
- flush_i  in  1  control-mispredict flush; synchronous, highest priority.
- decPacket_i  in  renPkt[0:SLOTS-1]  decoded bundle; per-slot `.valid`.
- decValid_i  in  1  bundle on decPacket_i is offered this cycle.
- decReady_o  out  1  stage can accept a bundle this cycle.
- stallFetch_i  in  1  power-manager drain request; blocks presentation to the buffer.
- instBufferFull_i  in  1  instruction buffer cannot accept SLOTS packets.
- ibPacket_o  out  renPkt[0:SLOTS-1]  head bundle, compacted.
- decodeReady_o  out  1  head bundle is offered to the instruction buffer.
- pktCount_o  out  $clog2(SLOTS)+1  number of valid packets in the head bundle.
- bundleCount_o  out  2  bundles held (0..2).

## Operation
- Storage is a 2-entry circular bundle queue with 1-bit head and tail pointers and a 2-bit count. Each entry holds SLOTS packets plus its packet count.
- State is derived from count: EMPTY (0), ONE (1), FULL (2).
- decReady_o = (count != 2). It depends on registered state only and never on decValid_i.
- **Enqueue** fires when decValid_i & decReady_o & ~flush_i.
  - Compaction: input slot i with valid=1 goes to output slot k, where k = number of valid slots below i. Output slots k ≥ popcount are written with valid=0.
  - A bundle with popcount 0 is accepted (handshake completes) but not stored; count is unchanged.
- **Presentation**
  - decodeReady_o = (count != 0) & ~stallFetch_i.
  - ibPacket_o = head entry when count != 0; otherwise all slots have valid=0 and the data fields are don't-care.
  - pktCount_o = head count when count != 0, else 0.
- **Dequeue** fires when decodeReady_o & ~instBufferFull_i & ~flush_i. This is exactly the condition under which the instruction buffer writes.
- Transitions:
  - EMPTY → ONE on a non-empty enqueue.
  - ONE → FULL on enqueue without dequeue.
  - ONE → EMPTY on dequeue without enqueue.
  - ONE → ONE on simultaneous enqueue and dequeue.
  - FULL → ONE on dequeue. No enqueue is possible in FULL.
- flush_i: count, head and tail go to 0 on the next edge; any bundle offered that cycle is discarded.
- Pointer wrap: the 1-bit pointers wrap naturally, 1 → 0.

## Timing
- Reset values (reset low): count=0, pointers=0, decReady_o=1, decodeReady_o=0, ibPacket_o all valid=0, pktCount_o=0, bundleCount_o=0.
- Latency: a bundle accepted at edge N appears on ibPacket_o in cycle N+1. There is no combinational bypass.
- Throughput is one bundle per cycle in steady state (ONE with simultaneous enqueue and dequeue).
- All outputs are functions of registered state plus stallFetch_i. There is no combinational path from decValid_i or instBufferFull_i to any output.
- Reset asserted mid-transfer: held bundles are lost; decReady_o reads 1 during and after reset.
- stallFetch_i high: decodeReady_o is low the same cycle and the held bundle stays intact. Enqueue continues until FULL.

## Structure
- Shared package: `renPkt` typedef, `SLOTS`, and a `bundle_t` struct (renPkt[SLOTS], count). The package carries no logic.
- One sub-module, `pkt_compactor`: purely combinational prefix-count compaction of SLOTS packets, also producing popcount. It is instantiated once, on the enqueue path.
- Top level holds the queue, pointers, count and output muxing; 120–250 lines total.

## Test plan
- Reset, then bundle with valid=8'b1010_0101 (slot0 LSB) and instBufferFull_i=0 → next cycle decodeReady_o=1, pktCount_o=4, ibPacket_o slots 0–3 = input slots 0,2,5,7 in order, slots 4–7 invalid.
- Three full bundles A, B, C on consecutive cycles with instBufferFull_i=1 → A and B stored, decReady_o=0 in the third cycle, C not accepted; release full → A then B drain in order, decReady_o=1 after A leaves.
- Bundle with valid=0 → handshake completes, bundleCount_o stays 0, decodeReady_o stays 0.
- Queue at ONE with continuous one-per-cycle input and instBufferFull_i=0 → one bundle dequeued per cycle and bundleCount_o stays 1.
- Queue FULL, flush_i pulsed while decValid_i=1 → next cycle bundleCount_o=0, decodeReady_o=0, decReady_o=1, offered bundle absent.
- stallFetch_i=1 with 1 bundle held → decodeReady_o=0, contents unchanged; reset pulled low mid-stall → all outputs at reset values asynchronously.
